instr_feeder: RTL and testbench

//   Upstream stage of the Lab6 cpu. Holds a small program of 16-bit instructions

---
 rtl/instr_feeder_if.sv | 39 +++
 rtl/instr_feeder.sv | 151 +++++++++++++++
 tb/tb_instr_feeder.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_if.sv
`timescale 1ns/1ps
// instr_feeder_if
//   Bundles the instr_feeder program-load port, run control, cpu handshake
//   and status lines.
//   master : the feeder side (drives in/load/s/pc/busy/done/err)
//   slave  : the environment side (drives wr_*, len, start, w)
//   Signals:
//     wr_en, wr_addr[AW], wr_data[16]  program write port
//     len[AW+1], start                 run control
//     w                                cpu waiting flag (1 = cpu ready for s)
//     in[16], load, s                  instruction word and strobes to the cpu
//     pc[AW], busy, done, err          run status
interface instr_feeder_if #(
    parameter int AW = 3
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [AW:0]   len;
    logic          start;
    logic          w;
    logic [15:0]   in;
    logic          load;
    logic          s;
    logic [AW-1:0] pc;
    logic          busy;
    logic          done;
    logic          err;

    modport master (
        input  wr_en, wr_addr, wr_data, len, start, w,
        output in, load, s, pc, busy, done, err
    );

    modport slave (
        output wr_en, wr_addr, wr_data, len, start, w,
        input  in, load, s, pc, busy, done, err
    );
endinterface

// File: rtl/instr_feeder.sv
`timescale 1ns/1ps
// instr_feeder
//   Upstream stage of the Lab6 cpu. Holds a small program of 16-bit
//   instructions written through the switch interface and, on start, streams
//   them into the cpu: present the word on in, pulse load, pulse s, then wait
//   for the cpu to drop and re-raise w before moving on.
//   Ports:
//     clk    cpu clock, rising edge
//     reset  synchronous, active-high, priority over everything
//     bus    instr_feeder_if.master (write port, run control, cpu handshake,
//            status)
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | nothing run since reset; accepts writes and start
//   DONE   | last run completed (done=1); accepts writes and start
//   ERR    | cpu never acknowledged s (err=1); accepts writes and start
//   FETCH  | in <= mem[pc]
//   WAITW  | word presented, waiting for cpu w=1
//   LOAD   | load=1 this cycle
//   START  | s=1 this cycle, arm the ack timer
//   ACK    | waiting for w to fall; timer expiry -> ERR
//   RUN    | cpu executing, waiting for w to rise again
module instr_feeder #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int ACK_MAX = 15
) (
    input  logic           clk,
    input  logic           reset,
    instr_feeder_if.master bus
);
    localparam int            CW       = $clog2(ACK_MAX + 1);
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE  = (AW+1)'(1);
    localparam logic [CW-1:0] ACK_LOAD = CW'(ACK_MAX - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PC_ONE   = AW'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DONE,
        S_ERR,
        S_FETCH,
        S_WAITW,
        S_LOAD,
        S_START,
        S_ACK,
        S_RUN
    } state_t;

    state_t        state;
    logic [15:0]   mem [DEPTH];
    logic [AW:0]   len_q;
    logic [AW:0]   last_idx;
    logic [CW-1:0] ack_cnt;

    assign last_idx = len_q - LEN_ONE;

    // Program memory is not reset. Writes are locked out for the whole run so
    // the program cannot change under the cpu.
    always_ff @(posedge clk) begin
        if (!reset && bus.wr_en && !bus.busy) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            bus.in   <= '0;
            bus.load <= 1'b0;
            bus.s    <= 1'b0;
            bus.pc   <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            ack_cnt  <= '0;
            len_q    <= '0;
        end else begin
            // Strobes are single-cycle: only the transition into LOAD/START
            // raises them.
            bus.load <= 1'b0;
            bus.s    <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        bus.err <= 1'b0;
                        if (bus.len == '0) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state    <= S_FETCH;
                            bus.pc   <= '0;
                            len_q    <= (bus.len > DEPTH_W) ? DEPTH_W : bus.len;
                            bus.done <= 1'b0;
                            bus.busy <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    bus.in <= mem[bus.pc];
                    state  <= S_WAITW;
                end
                S_WAITW: begin
                    if (bus.w) begin
                        state    <= S_LOAD;
                        bus.load <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_START;
                    bus.s <= 1'b1;
                end
                S_START: begin
                    // Down-counter: terminal count 0 is reached after ACK_MAX
                    // cycles in ACK with w still high.
                    ack_cnt <= ACK_LOAD;
                    state   <= S_ACK;
                end
                S_ACK: begin
                    if (!bus.w) begin
                        state <= S_RUN;
                    end else if (ack_cnt == '0) begin
                        state    <= S_ERR;
                        bus.err  <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        ack_cnt <= ack_cnt - CNT_ONE;
                    end
                end
                S_RUN: begin
                    if (bus.w) begin
                        if ({1'b0, bus.pc} == last_idx) begin
                            state    <= S_DONE;
                            bus.done <= 1'b1;
                            bus.busy <= 1'b0;
                        end else begin
                            bus.pc <= bus.pc + PC_ONE;
                            state  <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_feeder.sv
`timescale 1ns/1ps
// tb_instr_feeder
//   Self-checking bench for instr_feeder. A behavioural cpu model drives w;
//   the expected instruction stream is simply the first min(len, DEPTH)
//   words of a bench-side copy of the program memory.
module tb_instr_feeder;
    localparam int DEPTH    = 8;
    localparam int AW       = 3;
    localparam int ACK_MAX  = 15;
    localparam int M_NORMAL = 0;
    localparam int M_HANG   = 1;
    localparam int M_MANUAL = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    instr_feeder_if #(.AW(AW)) bus ();

    instr_feeder #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .ACK_MAX(ACK_MAX)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int          nvec = 0;
    int          nerr = 0;
    int          cpu_mode = M_NORMAL;
    int          exec_fixed = 0;
    logic        w_cpu;
    logic        w_manual = 1'b1;
    logic [15:0] mem_model [DEPTH];
    logic [15:0] got [$];
    int          s_count = 0;
    int          last_s_cycle = 0;
    int          cycle = 0;
    logic        prev_load = 1'b0;
    logic [15:0] exp_in = '0;
    int          exp_pc = 0;

    assign bus.w = (cpu_mode == M_MANUAL) ? w_manual : w_cpu;

    task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cycle <= cycle + 1;

    // Strobe monitor: records every word latched by load and checks the
    // load/s ordering rules.
    always @(negedge clk) begin
        if (bus.load || bus.s) check_eq("load_s_excl", 32'(bus.load & bus.s), 32'd0);
        if (bus.s) begin
            check_eq("s_after_load", 32'(prev_load), 32'd1);
            s_count++;
            last_s_cycle = cycle;
        end
        if (bus.load) got.push_back(bus.in);
        prev_load = bus.load;
    end

    // Cpu model: drops w the cycle after s, raises it after the exec time.
    initial begin
        int e;
        w_cpu = 1'b1;
        forever begin
            @(negedge clk);
            if (cpu_mode == M_NORMAL && bus.s) begin
                e = (exec_fixed != 0) ? exec_fixed : int'($urandom_range(5, 1));
                @(posedge clk);
                #1 w_cpu = 1'b0;
                repeat (e) @(posedge clk);
                #1 w_cpu = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(int a, logic [15:0] d, bit commit);
        bus.wr_addr = AW'(a);
        bus.wr_data = d;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        if (commit) mem_model[a] = d;
    endtask

    task automatic check_reset_outputs(string tag);
        check_eq({tag, "_in"},   32'(bus.in),   32'd0);
        check_eq({tag, "_load"}, 32'(bus.load), 32'd0);
        check_eq({tag, "_s"},    32'(bus.s),    32'd0);
        check_eq({tag, "_pc"},   32'(bus.pc),   32'd0);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_err"},  32'(bus.err),  32'd0);
    endtask

    task automatic start_run(int l, bit with_wr, logic [15:0] wd);
        got.delete();
        s_count = 0;
        bus.len   = (AW+1)'(l);
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr_addr  = '0;
            bus.wr_data  = wd;
            bus.wr_en    = 1'b1;
            mem_model[0] = wd;
        end
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
    endtask

    task automatic finish_run(int n, string tag);
        int waited;
        waited = 0;
        while (!bus.done && !bus.err && waited < 800) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        if (n > 0) begin
            exp_pc = n - 1;
            exp_in = mem_model[n-1];
        end
        check_eq({tag, "_done"},  32'(bus.done), 32'd1);
        check_eq({tag, "_err"},   32'(bus.err),  32'd0);
        check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
        check_eq({tag, "_pc"},    32'(bus.pc),   32'(exp_pc));
        check_eq({tag, "_inhold"}, 32'(bus.in),  32'(exp_in));
        check_eq({tag, "_nload"}, 32'(got.size()), 32'(n));
        check_eq({tag, "_ns"},    32'(s_count), 32'(n));
        for (int i = 0; i < n && i < got.size(); i++) begin
            check_eq({tag, "_word"}, 32'(got[i]), 32'(mem_model[i]));
        end
        tick();
    endtask

    task automatic run_prog(int l, bit with_wr, logic [15:0] wd, string tag);
        int n;
        n = (l > DEPTH) ? DEPTH : l;
        start_run(l, with_wr, wd);
        @(negedge clk);
        check_eq({tag, "_done0"}, 32'(bus.done), (n == 0) ? 32'd1 : 32'd0);
        check_eq({tag, "_busy0"}, 32'(bus.busy), (n == 0) ? 32'd0 : 32'd1);
        check_eq({tag, "_err0"},  32'(bus.err),  32'd0);
        finish_run(n, tag);
    endtask

    initial begin
        int waited;
        int seen;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.len     = '0;
        bus.start   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        tick();
        reset = 1'b0;

        // Directed program of three words
        write_word(0, 16'hD105, 1'b1);
        write_word(1, 16'hD203, 1'b1);
        write_word(2, 16'hA0C1, 1'b1);
        for (int i = 3; i < DEPTH; i++) write_word(i, 16'($urandom), 1'b1);
        exec_fixed = 4;
        run_prog(3, 1'b0, 16'h0, "prog3");

        // Empty run
        run_prog(0, 1'b0, 16'h0, "len0");

        // Ack timeout: cpu never drops w
        cpu_mode = M_HANG;
        start_run(2, 1'b0, 16'h0);
        waited = 0;
        while (!bus.err && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check_eq("to_err",   32'(bus.err), 32'd1);
        check_eq("to_delay", 32'(cycle - last_s_cycle), 32'(ACK_MAX + 1));
        check_eq("to_pc",    32'(bus.pc),   32'd0);
        check_eq("to_busy",  32'(bus.busy), 32'd0);
        check_eq("to_done",  32'(bus.done), 32'd0);
        check_eq("to_nload", 32'(got.size()), 32'd1);
        exp_pc = 0;
        exp_in = mem_model[0];
        cpu_mode = M_NORMAL;
        tick();
        run_prog(2, 1'b0, 16'h0, "rerun");

        // Cpu not ready at start: feeder must wait in front of load
        w_manual = 1'b0;
        cpu_mode = M_MANUAL;
        start_run(1, 1'b0, 16'h0);
        repeat (8) @(negedge clk);
        check_eq("ww_nload", 32'(got.size()), 32'd0);
        check_eq("ww_busy",  32'(bus.busy), 32'd1);
        @(posedge clk);
        #1 w_manual = 1'b1;
        @(negedge clk);
        check_eq("ww_load_early", 32'(bus.load), 32'd0);
        @(negedge clk);
        check_eq("ww_load", 32'(bus.load), 32'd1);
        cpu_mode = M_NORMAL;
        finish_run(1, "ww");

        // Same-cycle write and start: the run sees the new word
        run_prog(1, 1'b1, 16'h5A3C, "wrstart");

        // Write/start while busy are ignored; reset during ACK of instr 1
        for (int i = 0; i < DEPTH; i++) write_word(i, 16'($urandom), 1'b1);
        start_run(3, 1'b0, 16'h0);
        bus.wr_addr = '0;
        bus.wr_data = ~mem_model[0];
        bus.wr_en   = 1'b1;
        bus.len     = '0;
        bus.start   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
        bus.start   = 1'b0;
        seen = 0;
        waited = 0;
        while (seen < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
            if (bus.s) seen++;
        end
        check_eq("mr_second_s", 32'(seen), 32'd2);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("mr");
        tick();
        reset = 1'b0;
        exp_pc = 0;
        exp_in = '0;
        repeat (8) tick();
        run_prog(8, 1'b0, 16'h0, "memkeep");

        // Over-long len is clamped to DEPTH
        run_prog(9, 1'b0, 16'h0, "len9");

        // Randomized programs, lengths and cpu execution times
        exec_fixed = 0;
        for (int it = 0; it < 14; it++) begin
            if ($urandom_range(1, 0) == 1)
                write_word(int'($urandom_range(DEPTH - 1, 0)), 16'($urandom), 1'b1);
            run_prog(int'($urandom_range(9, 0)), 1'b0, 16'h0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
